// File: rtl/serial_adder_ctrl_if.sv
// Requester-side handshake and operand/result bundle for the bit-serial adder.
// The master drives start and operands; the slave (adder) returns status and result.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, overflow
  );

endinterface

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder slice reused LSB-first over WIDTH cycles,
// with the carry held in a single flip-flop between cycles.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  serial_adder_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] aSr_q, aSr_d;
  logic [WIDTH-1:0] bSr_q, bSr_d;
  logic [WIDTH-1:0] sSr_q, sSr_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             aMsb_q, aMsb_d;
  logic             bMsb_q, bMsb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic             sliceSum;
  logic             sliceCarry;
  logic [WIDTH-1:0] sumNext;

  assign sliceSum   = aSr_q[0] ^ bSr_q[0] ^ carry_q;
  assign sliceCarry = (aSr_q[0] & bSr_q[0]) | (carry_q & (aSr_q[0] ^ bSr_q[0]));
  // Sum bits enter at the top so the LSB ends up at bit 0 after WIDTH shifts.
  assign sumNext    = {sliceSum, sSr_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    aSr_d   = aSr_q;
    bSr_d   = bSr_q;
    sSr_d   = sSr_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    aMsb_d  = aMsb_q;
    bMsb_d  = bMsb_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          aSr_d   = bus.a;
          bSr_d   = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          aMsb_d  = bus.a[WIDTH-1];
          bMsb_d  = bus.b[WIDTH-1];
          state_d = RUN;
        end
      end
      RUN: begin
        aSr_d   = aSr_q >> 1;
        bSr_d   = bSr_q >> 1;
        sSr_d   = sumNext;
        carry_d = sliceCarry;
        cnt_d   = cnt_q + CNT_W'(1);
        // Visible results only update on the final slice, so they hold during RUN.
        if (cnt_q == LAST_BIT) begin
          sum_d   = sumNext;
          cout_d  = sliceCarry;
          ovf_d   = (aMsb_q == bMsb_q) && (sliceSum != aMsb_q);
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      aSr_q   <= '0;
      bSr_q   <= '0;
      sSr_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      aMsb_q  <= 1'b0;
      bMsb_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      aSr_q   <= aSr_d;
      bSr_q   <= bSr_d;
      sSr_q   <= sSr_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      aMsb_q  <= aMsb_d;
      bMsb_q  <= bMsb_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy     = (state_q == RUN);
  assign bus.done     = done_q;
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl: an 8-bit instance for the main vectors
// and a 4-bit instance for the narrow-width case.
module tb_serial_adder_ctrl;

  logic clk;
  logic rst8;
  logic rst4;

  int checkCount;
  int passCount;
  logic [7:0] lastSum8;

  serial_adder_ctrl_if #(.WIDTH(8)) bus8 ();
  serial_adder_ctrl_if #(.WIDTH(4)) bus4 ();

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst8),
    .bus (bus8)
  );

  serial_adder_ctrl #(.WIDTH(4)) dut4 (
    .clk (clk),
    .rst (rst4),
    .bus (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Issue one 8-bit operation and follow it through to the done pulse.
  task automatic applyStimulus(input string tag, input logic [7:0] aIn,
                               input logic [7:0] bIn, input logic cinIn,
                               input logic [7:0] expSum, input logic expCout,
                               input logic expOvf);
    int idx;
    int busyCnt;
    int doneIdx;
    int holdErr;
    @(negedge clk);
    bus8.a     = aIn;
    bus8.b     = bIn;
    bus8.cin   = cinIn;
    bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    idx     = 1;
    busyCnt = 0;
    doneIdx = 0;
    holdErr = 0;
    while (idx <= 40 && doneIdx == 0) begin
      if (bus8.busy) begin
        busyCnt++;
        if (bus8.sum !== lastSum8) holdErr++;
      end
      if (bus8.done) begin
        doneIdx = idx;
      end else begin
        @(negedge clk);
        idx++;
      end
    end
    checkOutput({tag, ".latency"}, doneIdx, 9);
    checkOutput({tag, ".busyCycles"}, busyCnt, 8);
    checkOutput({tag, ".holdInRun"}, holdErr, 0);
    checkOutput({tag, ".sum"}, 32'(bus8.sum), 32'(expSum));
    checkOutput({tag, ".cout"}, 32'(bus8.cout), 32'(expCout));
    checkOutput({tag, ".overflow"}, 32'(bus8.overflow), 32'(expOvf));
    @(negedge clk);
    checkOutput({tag, ".donePulse"}, 32'(bus8.done), 0);
    lastSum8 = expSum;
  endtask

  initial begin
    int idx;
    int doneCnt;
    int doneIdx;
    int prevIdx;
    int holdErr;
    logic [7:0] sumAtDone;

    checkCount = 0;
    passCount  = 0;
    lastSum8   = 8'h00;
    bus8.start = 1'b0;
    bus8.a     = '0;
    bus8.b     = '0;
    bus8.cin   = 1'b0;
    bus4.start = 1'b0;
    bus4.a     = '0;
    bus4.b     = '0;
    bus4.cin   = 1'b0;
    rst8 = 1'b1;
    rst4 = 1'b1;
    repeat (2) @(negedge clk);
    rst8 = 1'b0;
    rst4 = 1'b0;
    checkOutput("reset.busy", 32'(bus8.busy), 0);
    checkOutput("reset.done", 32'(bus8.done), 0);
    checkOutput("reset.sum", 32'(bus8.sum), 0);
    checkOutput("reset.cout", 32'(bus8.cout), 0);
    checkOutput("reset.overflow", 32'(bus8.overflow), 0);

    applyStimulus("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    applyStimulus("ffPlus1", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus("a5Plus5aCin", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0);
    applyStimulus("posOvf", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    applyStimulus("negOvf", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

    // Second start and operand change mid-run must not disturb the operation.
    @(negedge clk);
    bus8.a     = 8'h12;
    bus8.b     = 8'h34;
    bus8.cin   = 1'b0;
    bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    doneCnt   = 0;
    holdErr   = 0;
    sumAtDone = 8'h00;
    for (int i = 1; i <= 30; i++) begin
      if (i == 3) begin
        bus8.start = 1'b1;
        bus8.a     = 8'hFF;
      end else begin
        bus8.start = 1'b0;
      end
      if (bus8.busy && bus8.sum !== lastSum8) holdErr++;
      if (bus8.done) begin
        doneCnt++;
        sumAtDone = bus8.sum;
      end
      @(negedge clk);
    end
    checkOutput("ignoreStart.sum", 32'(sumAtDone), 32'h46);
    checkOutput("ignoreStart.doneCount", doneCnt, 1);
    checkOutput("ignoreStart.holdInRun", holdErr, 0);
    lastSum8 = 8'h46;

    // Asynchronous reset during RUN cycle 4.
    bus8.a     = 8'h0F;
    bus8.b     = 8'h0F;
    bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("abort.busyBefore", 32'(bus8.busy), 1);
    #2 rst8 = 1'b1;
    #1;
    checkOutput("abort.busy", 32'(bus8.busy), 0);
    checkOutput("abort.done", 32'(bus8.done), 0);
    checkOutput("abort.sum", 32'(bus8.sum), 0);
    checkOutput("abort.cout", 32'(bus8.cout), 0);
    checkOutput("abort.overflow", 32'(bus8.overflow), 0);
    @(negedge clk);
    rst8 = 1'b0;
    doneCnt = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus8.done) doneCnt++;
      @(negedge clk);
    end
    checkOutput("abort.noDone", doneCnt, 0);
    lastSum8 = 8'h00;
    applyStimulus("afterAbort", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

    // Held start: back-to-back operations every WIDTH+2 cycles.
    @(negedge clk);
    bus8.a     = 8'h10;
    bus8.b     = 8'h20;
    bus8.cin   = 1'b0;
    bus8.start = 1'b1;
    doneCnt = 0;
    prevIdx = -1;
    idx     = 0;
    while (idx < 60 && doneCnt < 3) begin
      @(negedge clk);
      idx++;
      if (bus8.done) begin
        doneCnt++;
        checkOutput("heldStart.sum", 32'(bus8.sum), 32'h30);
        if (prevIdx >= 0) checkOutput("heldStart.interval", idx - prevIdx, 10);
        prevIdx = idx;
      end
    end
    bus8.start = 1'b0;
    checkOutput("heldStart.pulses", doneCnt, 3);
    repeat (2) @(negedge clk);

    // Narrow instance: WIDTH=4.
    bus4.a     = 4'hF;
    bus4.b     = 4'h1;
    bus4.cin   = 1'b0;
    bus4.start = 1'b1;
    @(negedge clk);
    bus4.start = 1'b0;
    idx     = 1;
    doneIdx = 0;
    while (idx <= 20 && doneIdx == 0) begin
      if (bus4.done) begin
        doneIdx = idx;
      end else begin
        @(negedge clk);
        idx++;
      end
    end
    checkOutput("w4.latency", doneIdx, 5);
    checkOutput("w4.sum", 32'(bus4.sum), 32'h0);
    checkOutput("w4.cout", 32'(bus4.cout), 1);
    checkOutput("w4.overflow", 32'(bus4.overflow), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
